// File: rtl/hs_pkg.sv
// Shared types and constants for the hard-swish lane unpacker.
package hs_pkg;

    localparam int unsigned DATA_WIDTH = 21;
    localparam int unsigned FRAC_BITS  = 7;
    localparam int unsigned LANES      = 4;
    localparam int unsigned OUT_WIDTH  = 8;

    localparam int unsigned LANE_W = DATA_WIDTH + 1;
    localparam int unsigned SUM_W  = LANE_W + 1;
    localparam int unsigned WORD_W = LANE_W * LANES;
    localparam int unsigned CNT_W  = $clog2(LANES);

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef logic [LANES-1:0][LANE_W-1:0] word_t;

    // Half-LSB of the output grid, added before the shift for round-half-up.
    function automatic logic [SUM_W-1:0] round_const();
        return SUM_W'(1) << (FRAC_BITS - 1);
    endfunction

endpackage

// File: rtl/hs_requant.sv
// Combinational requantizer: Q(FRAC_BITS) lane -> signed OUT_WIDTH integer.
// HS_UNPACK_SAT_EN selects saturation; otherwise the result wraps.
module hs_requant
    import hs_pkg::*;
(
    input  logic signed [LANE_W-1:0]    x,
    output logic signed [OUT_WIDTH-1:0] y
);

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] r;

    // One guard bit above the lane so the rounding add never overflows.
    assign sum = $signed({x[LANE_W-1], x}) + $signed(round_const());
    assign r   = sum >>> FRAC_BITS;

`ifdef HS_UNPACK_SAT_EN
    localparam logic signed [SUM_W-1:0] MAX_V =
        {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_V =
        {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    always_comb begin
        y = r[OUT_WIDTH-1:0];
        if (r > MAX_V) begin
            y = MAX_V[OUT_WIDTH-1:0];
        end else if (r < MIN_V) begin
            y = MIN_V[OUT_WIDTH-1:0];
        end
    end
`else
    logic unused_hi;

    assign y         = r[OUT_WIDTH-1:0];
    assign unused_hi = ^r[SUM_W-1:OUT_WIDTH];
`endif

endmodule

// File: rtl/hs_lane_unpacker.sv
// Single-word buffer that streams LANES requantized activations one per cycle.
// Optional feature macro: HS_UNPACK_SAT_EN (saturating requantization).
module hs_lane_unpacker
    import hs_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WORD_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]            out_lane,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    word_t              word_q;
    logic               load;
    logic               at_last;
    logic signed [LANE_W-1:0] lane_sel;

    assign at_last  = (cnt_q == LAST_LANE);
    assign in_ready = (state_q == EMPTY) || (at_last && out_ready);
    assign load     = in_valid && in_ready;

    // State register, lane counter and held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                word_q <= word_t'(in_data);
            end
        end
    end

    // Next-state: advance on accepted lanes; a load on the last lane restarts at lane 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == DRAIN && out_ready) begin
            if (!at_last) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                state_d = EMPTY;
                cnt_d   = '0;
            end
        end
        if (load) begin
            state_d = DRAIN;
            cnt_d   = '0;
        end
    end

    assign lane_sel  = $signed(word_q[cnt_q]);
    assign out_valid = (state_q == DRAIN);
    assign out_lane  = cnt_q;
    assign out_last  = at_last && out_valid;

    hs_requant u_requant (
        .x (lane_sel),
        .y (out_data)
    );

endmodule

// File: doc/hs_lane_unpacker.md
# hs_lane_unpacker

Consumer side of the hard-swish segment output. Accepts one packed word of LANES signed activations in fixed-point Q(FRAC_BITS) format and holds it in a single-word buffer. Emits the activations one lane per cycle over a valid/ready stream, requantized to signed OUT_WIDTH integers for the next-layer feature-map writer.

## Interface
- DATA_WIDTH, 21, base activation width; each packed lane is DATA_WIDTH+1 bits, signed
- FRAC_BITS, 7, fractional bits per lane (≥1)
- LANES, 4, lanes per packed word (power of two, ≥2)
- OUT_WIDTH, 8, signed output width (< DATA_WIDTH+1-FRAC_BITS)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  (DATA_WIDTH+1)*LANES  packed lanes; lane k in bits [(k+1)*(DATA_WIDTH+1)-1 : k*(DATA_WIDTH+1)]
- in_valid  input  1  in_data valid
- in_ready  output  1  unpacker can take a word this cycle
- out_data  output  OUT_WIDTH  requantized lane value, signed
- out_lane  output  $clog2(LANES)  index of lane on out_data
- out_last  output  1  high with the final lane of a word
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data

## Operation
- States: EMPTY (no word held), DRAIN (word held, lane counter cnt = next lane to emit).
- Input transfer when in_valid && in_ready: latch in_data, cnt←0, go to DRAIN.
- in_ready = (state==EMPTY) || (cnt==LANES-1 && out_ready). A new word is loaded in the same cycle the last lane is accepted; no bubble.
- Output transfer when out_valid && out_ready: if cnt<LANES-1, cnt←cnt+1. Otherwise go to EMPTY, or stay in DRAIN with cnt←0 if a new word is loaded in the same cycle.
- out_valid = (state==DRAIN). out_lane = cnt. out_last = (cnt==LANES-1) && out_valid.
- out_data, out_lane and out_last must stay stable while out_valid && !out_ready.
- Lane order is strictly 0, 1, …, LANES-1. No lane is skipped or repeated.
- Requantization of lane x (DATA_WIDTH+1 bits, signed):
  - r = (x + 2^(FRAC_BITS-1)) >>> FRAC_BITS, computed in DATA_WIDTH+2 bits so the add cannot overflow.
  - This is round-half-up: +1.5→2, −1.5→−1.
  - r is then reduced to OUT_WIDTH bits per Configuration.
- in_data is ignored while in_ready is low. out_ready is ignored while out_valid is low.

## Timing
- Reset values: state EMPTY, cnt 0, held word 0, in_ready 1, out_valid 0, out_last 0, out_lane 0, out_data 0.
- Latency: a word accepted at edge N presents lane 0 from cycle N+1.
- Throughput: with out_ready held high and in_valid continuous, one lane per cycle, LANES cycles per word.
- No combinational path from in_data or in_valid to any output. in_ready depends combinationally on out_ready only.
- rst asserted mid-DRAIN discards the held word. The first cycle after rst deasserts shows EMPTY / in_ready=1.
- Backpressure on the last lane holds in_ready low; the upstream word waits.

## Configuration
- HS_UNPACK_SAT_EN defined: r is saturated to [−2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)−1].
- HS_UNPACK_SAT_EN undefined: r is truncated to its low OUT_WIDTH bits, two's-complement wrap, no comparators.

## Structure
- Shared package hs_pkg holds:
  - LANE_W = DATA_WIDTH+1
  - the state enum {EMPTY, DRAIN}
  - the rounding-constant function 2^(FRAC_BITS-1)
- One sub-module hs_requant: purely combinational, DATA_WIDTH+1 bits in, OUT_WIDTH bits out. It carries the rounding and the HS_UNPACK_SAT_EN branch.
- Top level holds the FSM, the lane counter, the word register and the lane mux.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 → in_ready=1, out_valid=0, out_data=0 throughout; no word captured.
- Single word, lanes {896, −896, 192, −192}, out_ready=1:
  - out_data 7, −7, 2, −1 on consecutive cycles starting N+1;
  - out_lane 0..3; out_last only on lane 3.
- Saturation, lanes {25600, −25600, 16256, 0}:
  - with macro → 127, −128, 127, 0;
  - without macro → −56, 56, 127, 0.
- Back-to-back words, out_ready=1, in_valid=1 → 8 contiguous lanes. in_ready pulses high on lane-3 cycles only; no idle cycle between words.
- Backpressure: drop out_ready for 2 cycles during lane 2 → lane 2 data stable, cnt frozen, in_ready=0. Sequence resumes intact.
- Reset mid-drain: assert rst after lane 1 is accepted → out_valid=0 next cycle. A subsequent word starts at lane 0.
